// File: rtl/shift_receiver_16.sv
// rtl/shift_receiver_16.sv - serial word deserializer with high/low run-length measurement
module shift_receiver_16 #(
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             serial_in,
   output logic [15:0]      data_out,
   output logic             data_valid,
   output logic [CNT_W-1:0] pulse_len,
   output logic [CNT_W-1:0] gap_len,
   output logic             meas_valid,
   output logic             sat
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [15:0]      shreg;
   logic [3:0]       bit_cnt;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] high_cnt, high_d;
   logic [CNT_W-1:0] low_cnt, low_d;
   logic [CNT_W-1:0] pulse_d, gap_d;
   logic             meas_d, sat_d;

   // Deserializer: shift MSB-first, publish the word on the 16th enabled sample.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (clear) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         data_valid <= 1'b0;
      end else if (enable) begin
         shreg   <= {shreg[14:0], serial_in};
         bit_cnt <= bit_cnt + 4'd1;
         if (bit_cnt == 4'd15) begin
            data_out   <= {shreg[14:0], serial_in};
            data_valid <= 1'b1;
         end else begin
            data_valid <= 1'b0;
         end
      end else begin
         data_valid <= 1'b0;
      end
   end

   // Measurement FSM state, run counters and registered results.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         high_cnt   <= '0;
         low_cnt    <= '0;
         pulse_len  <= '0;
         gap_len    <= '0;
         meas_valid <= 1'b0;
         sat        <= 1'b0;
      end else begin
         state_q    <= state_d;
         high_cnt   <= high_d;
         low_cnt    <= low_d;
         pulse_len  <= pulse_d;
         gap_len    <= gap_d;
         meas_valid <= meas_d;
         sat        <= sat_d;
      end
   end

   // Next-state logic: runs count in saturating counters; a low-to-high edge closes a measurement.
   always_comb begin
      state_d = state_q;
      high_d  = high_cnt;
      low_d   = low_cnt;
      pulse_d = pulse_len;
      gap_d   = gap_len;
      meas_d  = 1'b0;
      sat_d   = sat;
      if (clear) begin
         state_d = IDLE;
         high_d  = '0;
         low_d   = '0;
         sat_d   = 1'b0;
      end else if (enable) begin
         case (state_q)
            IDLE: begin
               if (serial_in) begin
                  state_d = HIGH;
                  high_d  = CNT_ONE;
               end
            end
            HIGH: begin
               if (serial_in) begin
                  if (high_cnt == CNT_MAX) sat_d = 1'b1;
                  else                     high_d = high_cnt + CNT_ONE;
               end else begin
                  state_d = LOW;
                  low_d   = CNT_ONE;
               end
            end
            LOW: begin
               if (!serial_in) begin
                  if (low_cnt == CNT_MAX) sat_d = 1'b1;
                  else                    low_d = low_cnt + CNT_ONE;
               end else begin
                  pulse_d = high_cnt;
                  gap_d   = low_cnt;
                  meas_d  = 1'b1;
                  state_d = HIGH;
                  high_d  = CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_receiver_16.sv
// tb/tb_shift_receiver_16.sv - self-checking bench for shift_receiver_16
module tb_shift_receiver_16;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        enable;
   logic        serial_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic [4:0]  pulse_len;
   logic [4:0]  gap_len;
   logic        meas_valid;
   logic        sat;

   shift_receiver_16 #(.CNT_W(5)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (clear),
      .enable     (enable),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .pulse_len  (pulse_len),
      .gap_len    (gap_len),
      .meas_valid (meas_valid),
      .sat        (sat)
   );

   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   // reference model: counts samples and run lengths with plain integers
   logic [15:0] m_word, m_data;
   int          m_nbits;
   logic        m_dv, m_mv, m_sat, m_started, m_cur;
   int          m_run, m_prev_high;
   int          m_pulse, m_gap;

   // observations of the DUT used by the directed checks
   int          dv_count, mv_count;
   logic [15:0] last_data;
   int          last_pulse, last_gap;

   typedef struct {
      logic [15:0] word;
      int          exp_pulse;
      int          exp_gap;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int cap(input int v);
      return (v > 31) ? 31 : v;
   endfunction

   task automatic model_reset();
      m_word = '0; m_data = '0; m_nbits = 0; m_dv = 0; m_mv = 0; m_sat = 0;
      m_started = 0; m_cur = 0; m_run = 0; m_prev_high = 0; m_pulse = 0; m_gap = 0;
   endtask

   task automatic model_step(input logic e, input logic s, input logic c);
      m_dv = 0;
      m_mv = 0;
      if (c) begin
         m_word = '0; m_nbits = 0; m_started = 0; m_run = 0; m_sat = 0;
      end else if (e) begin
         m_word = {m_word[14:0], s};
         m_nbits++;
         if (m_nbits == 16) begin
            m_nbits = 0;
            m_data  = m_word;
            m_dv    = 1;
         end
         if (!m_started) begin
            if (s) begin m_started = 1; m_cur = 1; m_run = 1; end
         end else if (s == m_cur) begin
            m_run++;
            if (m_run > 31) m_sat = 1;
         end else begin
            if (m_cur) m_prev_high = m_run;
            else begin
               m_pulse = cap(m_prev_high);
               m_gap   = cap(m_run);
               m_mv    = 1;
            end
            m_cur = s;
            m_run = 1;
         end
      end
   endtask

   task automatic compare_all();
      chk("data_out",   data_out,   m_data);
      chk("data_valid", data_valid, m_dv);
      chk("pulse_len",  pulse_len,  m_pulse[4:0]);
      chk("gap_len",    gap_len,    m_gap[4:0]);
      chk("meas_valid", meas_valid, m_mv);
      chk("sat",        sat,        m_sat);
   endtask

   task automatic step(input logic e, input logic s, input logic c);
      enable = e; serial_in = s; clear = c;
      @(posedge clock);
      model_step(e, s, c);
      #1;
      compare_all();
      if (data_valid) begin dv_count++; last_data = data_out; end
      if (meas_valid) begin mv_count++; last_pulse = pulse_len; last_gap = gap_len; end
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) step(1'b1, w[i], 1'b0);
   endtask

   task automatic clear_obs();
      dv_count = 0; mv_count = 0; last_pulse = -1; last_gap = -1;
   endtask

   vec_t vecs[4];

   initial begin
      logic [15:0] w;
      logic        s;
      vecs[0] = '{16'hA5C3, -1, -1};
      vecs[1] = '{16'h8080,  1,  7};
      vecs[2] = '{16'hE000,  3, 13};
      vecs[3] = '{16'hFFE0, 11,  5};

      reset_n = 1'b0; clear = 1'b0; enable = 1'b0; serial_in = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1;
      step(1'b0, 1'b0, 1'b0);

      // table: clear, then stream each word three times
      foreach (vecs[k]) begin
         step(1'b0, 1'b0, 1'b1);
         clear_obs();
         send_word(vecs[k].word);
         chk("dv_once_per_word", dv_count, 1);
         chk("word_data", last_data, vecs[k].word);
         send_word(vecs[k].word);
         send_word(vecs[k].word);
         chk("dv_count_3words", dv_count, 3);
         if (vecs[k].exp_pulse >= 0) begin
            chk("pulse_tbl", last_pulse, vecs[k].exp_pulse);
            chk("gap_tbl",   last_gap,   vecs[k].exp_gap);
         end
      end

      // 40 ones, 2 zeros, one: saturated pulse
      step(1'b0, 1'b0, 1'b1);
      clear_obs();
      chk("sat_cleared", sat, 0);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("sat_mv",    meas_valid, 1);
      chk("sat_pulse", pulse_len, 31);
      chk("sat_gap",   gap_len, 2);
      chk("sat_flag",  sat, 1);

      // reset mid-word discards the partial word
      step(1'b0, 1'b0, 1'b1);
      w = 16'h5A5A;
      for (int i = 15; i >= 7; i--) step(1'b1, w[i], 1'b0);
      reset_n = 1'b0;
      model_reset();
      #2;
      chk("rst_data_out", data_out, 16'h0000);
      compare_all();
      @(posedge clock); #1;
      chk("rst_hold_data_out", data_out, 16'h0000);
      reset_n = 1'b1;
      clear_obs();
      send_word(16'h1234);
      chk("post_rst_dv", dv_count, 1);
      chk("post_rst_data", last_data, 16'h1234);

      // enable toggling every cycle
      clear_obs();
      w = 16'hFF00;
      for (int i = 15; i >= 0; i--) begin
         step(1'b1, w[i], 1'b0);
         step(1'b0, ~w[i], 1'b0);
      end
      chk("toggle_dv", dv_count, 1);
      chk("toggle_data", data_out, 16'hFF00);

      // clear with enable mid-word restarts the bit count, data_out kept
      clear_obs();
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      chk("clr_keeps_data", data_out, 16'hFF00);
      chk("clr_no_dv", data_valid, 0);
      send_word(16'hC0DE);
      chk("clr_restart_dv", dv_count, 1);
      chk("clr_restart_data", last_data, 16'hC0DE);

      // random runs with sparse enable gaps and occasional clears
      s = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) s = ~s;
         if ($urandom_range(0, 60) == 0) s = ~s;
         step(($urandom_range(0, 3) != 0), s, ($urandom_range(0, 150) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
